// File: rtl/buffer_controller_pkg.sv
// Shared types and constants for the line-copy engine.
package buffer_controller_pkg;

  localparam int LINE_W  = 512;
  localparam int MDATA_W = 16;
  localparam logic [MDATA_W-1:0] CMPL_MDATA = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_DESC,
    ST_WAIT_DESC,
    ST_RUN,
    ST_DRAIN,
    ST_COMPLETE,
    ST_WAIT_CMPL,
    ST_DONE
  } t_bc_state;

  typedef struct packed {
    logic [LINE_W-1:0]  data;
    logic [MDATA_W-1:0] tag;
  } t_fifo_entry;

endpackage

// File: rtl/bc_line_fifo.sv
// Synchronous FIFO of read-response lines; head entry is visible without a pop.
module bc_line_fifo
  import buffer_controller_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  t_fifo_entry push_entry,
  input  logic        pop,
  output t_fifo_entry head_entry,
  output logic        empty,
  output logic        full
);

  localparam int AW = $clog2(DEPTH);

  t_fifo_entry mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign head_entry = mem[rd_ptr[AW-1:0]];
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/buffer_controller.sv
// Copy engine: read descriptor, stream N lines through a line buffer to the
// output region, then write a completion line for the host to poll.
module buffer_controller
  import buffer_controller_pkg::*;
#(
  parameter int BUF_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rst_parc,
  input  logic               start,
  input  logic [63:0]        workspace_addr_base,
  output logic               req_rd_en,
  input  logic               req_rd_available,
  output logic [63:0]        req_rd_addr,
  output logic [MDATA_W-1:0] req_rd_mdata,
  input  logic               resp_rd_valid,
  input  logic [LINE_W-1:0]  resp_rd_data,
  input  logic [MDATA_W-1:0] resp_rd_mdata,
  input  logic               req_wr_available,
  output logic               req_wr_en,
  output logic [63:0]        req_wr_addr,
  output logic [MDATA_W-1:0] req_wr_mdata,
  output logic [LINE_W-1:0]  req_wr_data,
  input  logic               resp_wr_valid,
  input  logic [MDATA_W-1:0] resp_wr_mdata
);

  localparam int CNT_W = 17;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  t_bc_state        state;
  logic [63:0]      base;
  logic [CNT_W-1:0] n_lines, rd_issued, wr_issued, wr_acked;
  logic             sync_rst, rd_go, wr_go, fifo_push, fifo_empty, fifo_full_unused;
  logic [5:0]       addr_lsb_unused;
  t_fifo_entry      push_entry, head_entry;

  assign sync_rst        = rst | rst_parc;
  assign addr_lsb_unused = workspace_addr_base[5:0];

  // Credit on (issued - drained) bounds buffer occupancy, so pushes never overflow.
  assign rd_go = (state == ST_RUN) && req_rd_available && (rd_issued < n_lines) &&
                 ((rd_issued - wr_issued) < DEPTH_C);
  assign wr_go      = (state == ST_RUN) && !fifo_empty && req_wr_available;
  assign fifo_push  = (state == ST_RUN) && resp_rd_valid;
  assign push_entry = '{data: resp_rd_data, tag: resp_rd_mdata};

  bc_line_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (sync_rst),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (wr_go),
    .head_entry (head_entry),
    .empty      (fifo_empty),
    .full       (fifo_full_unused)
  );

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state        <= ST_IDLE;
      base         <= '0;
      n_lines      <= '0;
      rd_issued    <= '0;
      wr_issued    <= '0;
      wr_acked     <= '0;
      req_rd_en    <= 1'b0;
      req_rd_addr  <= '0;
      req_rd_mdata <= '0;
      req_wr_en    <= 1'b0;
      req_wr_addr  <= '0;
      req_wr_mdata <= '0;
      req_wr_data  <= '0;
    end else begin
      req_rd_en <= 1'b0;
      req_wr_en <= 1'b0;

      if (rd_go) begin
        req_rd_en    <= 1'b1;
        req_rd_addr  <= base + 64'd1 + 64'(rd_issued);
        req_rd_mdata <= rd_issued[MDATA_W-1:0];
        rd_issued    <= rd_issued + 1'b1;
      end

      // The tag, not arrival order, places each line in the output region.
      if (wr_go) begin
        req_wr_en    <= 1'b1;
        req_wr_addr  <= base + 64'd1 + 64'(n_lines) + 64'(head_entry.tag);
        req_wr_data  <= head_entry.data;
        req_wr_mdata <= head_entry.tag;
        wr_issued    <= wr_issued + 1'b1;
      end

      if (resp_wr_valid && (state == ST_RUN || state == ST_DRAIN))
        wr_acked <= wr_acked + 1'b1;

      case (state)
        ST_IDLE: if (start) begin
          base      <= {6'b0, workspace_addr_base[63:6]};
          rd_issued <= '0;
          wr_issued <= '0;
          wr_acked  <= '0;
          state     <= ST_RD_DESC;
        end
        ST_RD_DESC: if (req_rd_available) begin
          req_rd_en    <= 1'b1;
          req_rd_addr  <= base;
          req_rd_mdata <= '0;
          state        <= ST_WAIT_DESC;
        end
        ST_WAIT_DESC: if (resp_rd_valid) begin
          n_lines <= CNT_W'(resp_rd_data[15:0]);
          state   <= (resp_rd_data[15:0] == 16'd0) ? ST_COMPLETE : ST_RUN;
        end
        ST_RUN:   if (wr_issued == n_lines) state <= ST_DRAIN;
        ST_DRAIN: if (wr_acked == n_lines)  state <= ST_COMPLETE;
        ST_COMPLETE: if (req_wr_available) begin
          req_wr_en    <= 1'b1;
          req_wr_addr  <= base + 64'd1 + (64'(n_lines) << 1);
          req_wr_data  <= LINE_W'({32'(n_lines), 32'h0000_0001});
          req_wr_mdata <= CMPL_MDATA;
          state        <= ST_WAIT_CMPL;
        end
        ST_WAIT_CMPL: if (resp_wr_valid && resp_wr_mdata == CMPL_MDATA) state <= ST_DONE;
        ST_DONE:      if (!start) state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_controller.sv
// Directed bench: a host memory model answers reads/writes; each job's output
// region and completion line are compared against hand-derived values.
module tb_buffer_controller;
  import buffer_controller_pkg::*;

  localparam int BUF_DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst, rst_parc, start;
  logic [63:0]        workspace_addr_base;
  logic               req_rd_en, req_rd_available;
  logic [63:0]        req_rd_addr;
  logic [MDATA_W-1:0] req_rd_mdata;
  logic               resp_rd_valid;
  logic [LINE_W-1:0]  resp_rd_data;
  logic [MDATA_W-1:0] resp_rd_mdata;
  logic               req_wr_available, req_wr_en;
  logic [63:0]        req_wr_addr;
  logic [MDATA_W-1:0] req_wr_mdata;
  logic [LINE_W-1:0]  req_wr_data;
  logic               resp_wr_valid;
  logic [MDATA_W-1:0] resp_wr_mdata;

  buffer_controller #(.BUF_DEPTH(BUF_DEPTH)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rst_parc            (rst_parc),
    .start               (start),
    .workspace_addr_base (workspace_addr_base),
    .req_rd_en           (req_rd_en),
    .req_rd_available    (req_rd_available),
    .req_rd_addr         (req_rd_addr),
    .req_rd_mdata        (req_rd_mdata),
    .resp_rd_valid       (resp_rd_valid),
    .resp_rd_data        (resp_rd_data),
    .resp_rd_mdata       (resp_rd_mdata),
    .req_wr_available    (req_wr_available),
    .req_wr_en           (req_wr_en),
    .req_wr_addr         (req_wr_addr),
    .req_wr_mdata        (req_wr_mdata),
    .req_wr_data         (req_wr_data),
    .resp_wr_valid       (resp_wr_valid),
    .resp_wr_mdata       (resp_wr_mdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]        addr;
    logic [MDATA_W-1:0] md;
  } rd_t;

  int n_checks = 0;
  int n_errors = 0;

  // host model state
  rd_t               rdq[$];
  rd_t               r_ent;
  logic [MDATA_W-1:0] wq[$];
  logic [LINE_W-1:0] wmem [logic [63:0]];
  logic [63:0]       cur_base;
  int                cur_n;
  logic [LINE_W-1:0] desc_line;
  bit                rev_mode, rd_toggle;
  int                wr_block, rd_idle, rd_total, rd_data, wr_data, cmpl_cnt;
  int                proto_err, viol, max_out, reads_at_unblock;
  logic [63:0]       cmpl_addr;
  logic [LINE_W-1:0] cmpl_data;

  function automatic logic [LINE_W-1:0] pat(input logic [63:0] a);
    logic [LINE_W-1:0] v;
    for (int k = 0; k < 8; k++) v[64*k +: 64] = a * 64'h9E37_79B9_7F4A_7C15 + 64'(k);
    return v;
  endfunction

  task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Host memory: answers queued reads/writes one per cycle, then records new requests.
  initial begin
    forever begin
      @(negedge clk);
      resp_rd_valid = 1'b0;
      resp_wr_valid = 1'b0;
      if (rdq.size() > 0 && (!rev_mode || rdq.size() >= BUF_DEPTH || rd_idle >= 3)) begin
        r_ent = rev_mode ? rdq.pop_back() : rdq.pop_front();
        resp_rd_valid = 1'b1;
        resp_rd_mdata = r_ent.md;
        resp_rd_data  = (r_ent.addr == cur_base) ? desc_line : pat(r_ent.addr);
      end
      if (wq.size() > 0) begin
        resp_wr_valid = 1'b1;
        resp_wr_mdata = rev_mode ? wq.pop_back() : wq.pop_front();
      end
      if (req_rd_en) begin
        if (!req_rd_available) viol++;
        if (rd_total == 0) begin
          if (req_rd_addr != cur_base || req_rd_mdata != 16'd0) proto_err++;
        end else begin
          if (req_rd_addr != cur_base + 64'd1 + 64'(rd_data) || req_rd_mdata != 16'(rd_data)) proto_err++;
          rd_data++;
        end
        rd_total++;
        rdq.push_back('{addr: req_rd_addr, md: req_rd_mdata});
        rd_idle = 0;
      end else begin
        rd_idle++;
      end
      if (req_wr_en) begin
        if (!req_wr_available) viol++;
        if (req_wr_mdata == 16'hFFFF) begin
          cmpl_cnt++;
          cmpl_addr = req_wr_addr;
          cmpl_data = req_wr_data;
        end else begin
          if (req_wr_addr != cur_base + 64'd1 + 64'(cur_n) + 64'(req_wr_mdata)) proto_err++;
          wmem[req_wr_addr] = req_wr_data;
          wr_data++;
        end
        wq.push_back(req_wr_mdata);
      end
      if (rd_data - wr_data > max_out) max_out = rd_data - wr_data;
      if (wr_block > 0) begin
        wr_block--;
        if (wr_block == 0) reads_at_unblock = rd_data;
      end
      req_wr_available = (wr_block == 0);
      req_rd_available = rd_toggle ? !req_rd_available : 1'b1;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_rd_en"},    1'(req_rd_en), 1'b0);
    check({tag, "_wr_en"},    1'(req_wr_en), 1'b0);
    check({tag, "_rd_addr"},  req_rd_addr, '0);
    check({tag, "_rd_mdata"}, req_rd_mdata, '0);
    check({tag, "_wr_addr"},  req_wr_addr, '0);
    check({tag, "_wr_mdata"}, req_wr_mdata, '0);
    check({tag, "_wr_data"},  req_wr_data, '0);
    check({tag, "_state"},    dut.state, ST_IDLE);
  endtask

  task automatic prep_job(input logic [63:0] ws, input int n, input bit rev, input bit tog, input int blk);
    @(posedge clk);
    rdq.delete(); wq.delete(); wmem.delete();
    cur_base = ws >> 6; cur_n = n; rev_mode = rev; rd_toggle = tog; wr_block = blk;
    rd_idle = 0; rd_total = 0; rd_data = 0; wr_data = 0; cmpl_cnt = 0;
    proto_err = 0; viol = 0; max_out = 0; reads_at_unblock = -1;
    cmpl_addr = '0; cmpl_data = '0;
    desc_line = pat(ws >> 6);
    desc_line[31:0] = 32'(n);
    workspace_addr_base = ws;
  endtask

  task automatic run_job(input string tag, input logic [63:0] ws, input int n,
                         input bit rev, input bit tog, input int blk);
    int t;
    logic [63:0] a;
    prep_job(ws, n, rev, tog, blk);
    @(negedge clk);
    start = 1'b1;
    t = 0;
    while (cmpl_cnt == 0 && t < 4000) begin @(negedge clk); t++; end
    check({tag, "_cmpl_seen"}, 1'(t < 4000), 1'b1);
    repeat (4) @(negedge clk);
    check({tag, "_state_done"}, dut.state, ST_DONE);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_state_idle"}, dut.state, ST_IDLE);
    check({tag, "_cmpl_addr"}, cmpl_addr, cur_base + 64'd1 + 64'(2 * n));
    check({tag, "_cmpl_data"}, cmpl_data, LINE_W'({32'(n), 32'h0000_0001}));
    check({tag, "_cmpl_cnt"}, cmpl_cnt, 1);
    check({tag, "_rd_count"}, rd_data, n);
    check({tag, "_wr_count"}, wr_data, n);
    check({tag, "_proto"}, proto_err, 0);
    check({tag, "_avail_viol"}, viol, 0);
    check({tag, "_credit"}, 1'(max_out <= BUF_DEPTH), 1'b1);
    for (int i = 0; i < n; i++) begin
      a = cur_base + 64'd1 + 64'(n) + 64'(i);
      check($sformatf("%s_line%0d", tag, i), wmem.exists(a) ? wmem[a] : '0, pat(cur_base + 64'd1 + 64'(i)));
    end
    $display("job %s: n=%0d base=%0h done, errors so far %0d", tag, n, cur_base, n_errors);
  endtask

  initial begin
    int t;
    rst = 1'b1; rst_parc = 1'b0; start = 1'b0; workspace_addr_base = '0;
    req_rd_available = 1'b1; req_wr_available = 1'b1;
    resp_rd_valid = 1'b0; resp_rd_data = '0; resp_rd_mdata = '0;
    resp_wr_valid = 1'b0; resp_wr_mdata = '0;
    cur_base = '0; cur_n = 0; desc_line = '0; rev_mode = 0; rd_toggle = 0; wr_block = 0;
    rd_idle = 0; rd_total = 0; rd_data = 0; wr_data = 0; cmpl_cnt = 0;
    proto_err = 0; viol = 0; max_out = 0; reads_at_unblock = -1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_job("n4",     64'h0000_0000_1000_0000, 4,  0, 0, 0);
    run_job("n40blk", 64'h0000_0001_0000_1025, 40, 0, 0, 50);
    check("n40blk_reads_capped", reads_at_unblock, BUF_DEPTH);
    run_job("n8rev",  64'h0000_0000_2000_0040, 8,  1, 0, 0);
    run_job("n0",     64'h0000_0000_3000_0000, 0,  0, 0, 0);
    run_job("n6tog",  64'h0000_0000_4000_0000, 6,  0, 1, 0);

    // abort mid-RUN with the soft reset, then a fresh job
    prep_job(64'h0000_0000_5000_0000, 10, 0, 0, 0);
    @(negedge clk);
    start = 1'b1;
    t = 0;
    while (rd_data < 3 && t < 500) begin @(negedge clk); t++; end
    check("parc_reached_run", 1'(rd_data >= 3), 1'b1);
    rst_parc = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst_parc = 1'b0;
    check_zero("parc");
    repeat (20) @(negedge clk);
    check("parc_idle_hold", dut.state, ST_IDLE);
    run_job("restart", 64'h0000_0000_5000_0000, 5, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
